bullet_scheduler: RTL and testbench
===================================

Name: bullet_scheduler

Overview:
- Owns a shared pool of bullet slots for the two tanks.
- Arbitrates fire requests from both players into free slots and spawns each bullet at the muzzle of its tank.
- Advances every live bullet once per frame and retires bullets that leave the screen.
- Sits between the per-tank movement controllers and the colour mapper; supplies per-pixel is_bullet / bullet_owner.

Parameters:
NUM_SLOTS, 4, bullet slots in pool (1..8)
BULLET_STEP, 10'd4, pixels moved per frame
BULLET_SIZE, 10'd8, bullet square edge in pixels
TANK_SIZE, 10'd32, tank square edge in pixels
COOLDOWN, 6'd15, frames a player must wait after a granted shot
X_MAX, 10'd639, rightmost pixel
Y_MAX, 10'd479, bottommost pixel

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  ~60 Hz frame clock, asynchronous to Clk
fire_req  in  2  per-player fire level (bit0 = player0)
tank0_X, tank0_Y  in  10 each  player0 top-left position
tank1_X, tank1_Y  in  10 each  player1 top-left position
tank0_dir, tank1_dir  in  3 each  1=up, 2=right, 3=left, 4=down
DrawX, DrawY  in  10 each  current pixel
fire_grant  out  2  one-Clk pulse per player on a granted shot
fire_drop  out  2  one-Clk pulse per player when a request finds no free slot
active_count  out  4  number of live slots
is_bullet  out  1  current pixel lies inside any live bullet
bullet_owner  out  1  owner of the lowest-index bullet covering the pixel
hit  out  2  one-Clk pulse, bit n = player n was hit (feature only)

Behaviour:
- Reset is asynchronous and active-low. Reset_n=0 immediately clears:
  - all slots inactive
  - cooldowns 0, fire_prev 0
  - priority = player0
  - all pulse outputs 0, active_count 0
- Reset mid-frame discards all live bullets.
- frame_clk passes through a 2-flop synchronizer plus an edge register. tick = one-Clk pulse on the synchronized rising edge.
- All slot state changes only on tick. No activity between ticks.
- On tick, in this order within one cycle:
  1. Advance: each live slot moves BULLET_STEP in its stored dir.
  2. Retire: a slot is retired instead of advancing if the move would leave the screen:
     - up: y < BULLET_STEP
     - left: x < BULLET_STEP
     - down: y + BULLET_STEP + BULLET_SIZE > Y_MAX
     - right: x + BULLET_STEP + BULLET_SIZE > X_MAX
     - The comparison is done in 11 bits, so there is no 10-bit wrap.
  3. Allocate: a player is eligible if fire_req rose since the previous tick (fire_req=1, fire_prev=0), cooldown==0, and dir is 1-4.
     - Free slots are those inactive before this tick. Slots retired on this tick are not reusable until the next tick.
     - One eligible player: takes the lowest free slot.
     - Both eligible, at least 2 free: priority player takes the lowest slot, the other takes the next.
     - Both eligible, exactly 1 free: priority player wins, the other gets fire_drop, and priority toggles.
     - Zero free: every eligible player gets fire_drop.
  4. fire_prev <= fire_req. Holding fire yields exactly one shot.
  5. Cooldown: a granted player loads COOLDOWN; every other nonzero cooldown decrements by 1 per tick.
- Spawn position (x, y), with S = BULLET_SIZE:
  - up: (tX + 12, tY − S), clamped to 0
  - down: (tX + 12, tY + TANK_SIZE)
  - left: (tX − S, tY + 12), clamped to 0
  - right: (tX + TANK_SIZE, tY + 12)
  - The offset 12 = (TANK_SIZE − S)/2.
- An invalid dir (0, 5-7) is ignored: no grant, no drop. fire_prev still updates.
- fire_grant, fire_drop and hit are registered. They pulse in the cycle after tick, for exactly one Clk.
- active_count updates in the same cycle.
- Pixel test is combinational. A slot covers the pixel if it is active, x ≤ DrawX ≤ x+S−1, and y ≤ DrawY ≤ y+S−1.
- bullet_owner = 0 when is_bullet = 0.

Optional Feature:
- Macro BULLET_HIT_EN.
- Defined:
  - After the advance step, a live bullet whose box overlaps the opposing tank box (TANK_SIZE square at tankN_X/Y) is retired.
  - hit[target] pulses.
  - Multiple bullets hitting in one tick give a single pulse.
  - A bullet never hits its own owner.
- Undefined: hit tied to 2'b00; bullets pass through tanks.

Test Plan:
1. Reset_n=0 mid-frame with 3 live bullets -> is_bullet=0, active_count=0 immediately. After release, first shot lands in slot 0.
2. Player0 at (100,200), dir=2, fire_req0 0→1 -> fire_grant=2'b01 one cycle after tick. Bullet drawn at (132..139, 212..219). Next tick x=136.
3. Both fire on the same tick with 1 free slot, priority=player0 -> fire_grant=01, fire_drop=10. Repeat with 1 free -> fire_grant=10.
4. fire_req0 held high for 40 frames -> exactly one grant. Release, then press at frame 10 after grant -> ignored by cooldown. Press at frame 16 -> granted.
5. Bullet dir=1 at y=3 -> retired on next tick, no underflow to y≈1020. Bullet dir=2 at x=628 -> retired, active_count decrements.
6. BULLET_HIT_EN: player1 at (300,200), player0 bullet moving right at x=290,y=212 -> next tick hit=2'b10, slot freed. Without macro, bullet continues to x=294.

Source files
------------

// File: rtl/bullet_scheduler_if.sv
// Bundle between the tank controllers/colour mapper (master) and the bullet scheduler (slave).
interface bullet_scheduler_if;
  logic [1:0] fire_req;
  logic [9:0] tank0_X;
  logic [9:0] tank0_Y;
  logic [9:0] tank1_X;
  logic [9:0] tank1_Y;
  logic [2:0] tank0_dir;
  logic [2:0] tank1_dir;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [1:0] fire_grant;
  logic [1:0] fire_drop;
  logic [3:0] active_count;
  logic       is_bullet;
  logic       bullet_owner;
  logic [1:0] hit;

  modport master (
    output fire_req, tank0_X, tank0_Y, tank1_X, tank1_Y, tank0_dir, tank1_dir, DrawX, DrawY,
    input  fire_grant, fire_drop, active_count, is_bullet, bullet_owner, hit
  );

  modport slave (
    input  fire_req, tank0_X, tank0_Y, tank1_X, tank1_Y, tank0_dir, tank1_dir, DrawX, DrawY,
    output fire_grant, fire_drop, active_count, is_bullet, bullet_owner, hit
  );
endinterface

// File: rtl/bullet_scheduler.sv
// Shared bullet pool for two tanks: per-frame advance/retire, fire arbitration, per-pixel lookup.
// Define BULLET_HIT_EN to retire bullets that strike the opposing tank and pulse hit.
module bullet_scheduler #(
  parameter int         NUM_SLOTS   = 4,
  parameter logic [9:0] BULLET_STEP = 10'd4,
  parameter logic [9:0] BULLET_SIZE = 10'd8,
  parameter logic [9:0] TANK_SIZE   = 10'd32,
  parameter logic [5:0] COOLDOWN    = 6'd15,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] Y_MAX       = 10'd479
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  bullet_scheduler_if.slave bus
);

  localparam int         IW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [9:0] MUZZLE = (TANK_SIZE - BULLET_SIZE) >> 1;

  function automatic logic dir_ok(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd4);
  endfunction

  // Edge tests widened to 11 bits so x/y near 1023 cannot wrap.
  function automatic logic leaves_screen(input logic [9:0] x, input logic [9:0] y, input logic [2:0] d);
    logic [10:0] far_x;
    logic [10:0] far_y;
    logic        res;
    far_x = {1'b0, x} + {1'b0, BULLET_STEP} + {1'b0, BULLET_SIZE};
    far_y = {1'b0, y} + {1'b0, BULLET_STEP} + {1'b0, BULLET_SIZE};
    case (d)
      3'd1:    res = (y < BULLET_STEP);
      3'd2:    res = (far_x > {1'b0, X_MAX});
      3'd3:    res = (x < BULLET_STEP);
      3'd4:    res = (far_y > {1'b0, Y_MAX});
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [19:0] step_pos(input logic [9:0] x, input logic [9:0] y, input logic [2:0] d);
    logic [9:0] nx;
    logic [9:0] ny;
    nx = x;
    ny = y;
    case (d)
      3'd1:    ny = y - BULLET_STEP;
      3'd2:    nx = x + BULLET_STEP;
      3'd3:    nx = x - BULLET_STEP;
      3'd4:    ny = y + BULLET_STEP;
      default: ;
    endcase
    return {nx, ny};
  endfunction

  function automatic logic [19:0] spawn_pos(input logic [9:0] tx, input logic [9:0] ty, input logic [2:0] d);
    logic [9:0] nx;
    logic [9:0] ny;
    nx = tx + MUZZLE;
    ny = ty + MUZZLE;
    case (d)
      3'd1:    ny = (ty >= BULLET_SIZE) ? ty - BULLET_SIZE : 10'd0;
      3'd2:    nx = tx + TANK_SIZE;
      3'd3:    nx = (tx >= BULLET_SIZE) ? tx - BULLET_SIZE : 10'd0;
      3'd4:    ny = ty + TANK_SIZE;
      default: ;
    endcase
    return {nx, ny};
  endfunction

  function automatic logic in_box(input logic [9:0] bx, input logic [9:0] by,
                                  input logic [9:0] px, input logic [9:0] py);
    logic [10:0] last_x;
    logic [10:0] last_y;
    last_x = {1'b0, bx} + {1'b0, BULLET_SIZE} - 11'd1;
    last_y = {1'b0, by} + {1'b0, BULLET_SIZE} - 11'd1;
    return (px >= bx) && ({1'b0, px} <= last_x) && (py >= by) && ({1'b0, py} <= last_y);
  endfunction

`ifdef BULLET_HIT_EN
  function automatic logic box_overlap(input logic [9:0] bx, input logic [9:0] by,
                                       input logic [9:0] tx, input logic [9:0] ty);
    return ({1'b0, bx} < {1'b0, tx} + {1'b0, TANK_SIZE}) &&
           ({1'b0, tx} < {1'b0, bx} + {1'b0, BULLET_SIZE}) &&
           ({1'b0, by} < {1'b0, ty} + {1'b0, TANK_SIZE}) &&
           ({1'b0, ty} < {1'b0, by} + {1'b0, BULLET_SIZE});
  endfunction
`endif

  logic fc_meta_q, fc_sync_q, fc_prev_q;
  logic tick;

  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic [NUM_SLOTS-1:0] own_q, own_d;
  logic [9:0]           x_q   [NUM_SLOTS];
  logic [9:0]           x_d   [NUM_SLOTS];
  logic [9:0]           y_q   [NUM_SLOTS];
  logic [9:0]           y_d   [NUM_SLOTS];
  logic [2:0]           dir_q [NUM_SLOTS];
  logic [2:0]           dir_d [NUM_SLOTS];
  logic [9:0]           adv_x [NUM_SLOTS];
  logic [9:0]           adv_y [NUM_SLOTS];

  logic [5:0] cd_q [2];
  logic [5:0] cd_d [2];
  logic [1:0] fire_prev_q, fire_prev_d;
  logic       prio_q, prio_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] drop_q, drop_d;

  logic [NUM_SLOTS-1:0] off_w, cover_w, strike_w;
  logic [1:0]           elig;
  logic [IW-1:0]        first_free, second_free;
  logic                 have_one, have_two;
  logic [IW-1:0]        sel [2];
  logic [19:0]          spawn [2];
  logic [3:0]           count_w;
  logic                 owner_w;

  assign tick = fc_sync_q & ~fc_prev_q;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign off_w[gi]                = leaves_screen(x_q[gi], y_q[gi], dir_q[gi]);
    assign {adv_x[gi], adv_y[gi]}   = step_pos(x_q[gi], y_q[gi], dir_q[gi]);
    assign cover_w[gi]              = act_q[gi] && in_box(x_q[gi], y_q[gi], bus.DrawX, bus.DrawY);
`ifdef BULLET_HIT_EN
    assign strike_w[gi] = act_q[gi] && !off_w[gi] &&
                          (own_q[gi] ? box_overlap(adv_x[gi], adv_y[gi], bus.tank0_X, bus.tank0_Y)
                                     : box_overlap(adv_x[gi], adv_y[gi], bus.tank1_X, bus.tank1_Y));
`else
    assign strike_w[gi] = 1'b0;
`endif
  end

  assign elig[0]  = bus.fire_req[0] && !fire_prev_q[0] && (cd_q[0] == 6'd0) && dir_ok(bus.tank0_dir);
  assign elig[1]  = bus.fire_req[1] && !fire_prev_q[1] && (cd_q[1] == 6'd0) && dir_ok(bus.tank1_dir);
  assign spawn[0] = spawn_pos(bus.tank0_X, bus.tank0_Y, bus.tank0_dir);
  assign spawn[1] = spawn_pos(bus.tank1_X, bus.tank1_Y, bus.tank1_dir);

  // Free slots are judged on pre-tick occupancy, so a slot retired this tick stays unusable.
  always_comb begin
    first_free  = '0;
    second_free = '0;
    have_one    = 1'b0;
    have_two    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!act_q[i]) begin
        if (!have_one) begin
          first_free = IW'(i);
          have_one   = 1'b1;
        end else if (!have_two) begin
          second_free = IW'(i);
          have_two    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    act_d       = act_q;
    own_d       = own_q;
    cd_d        = cd_q;
    fire_prev_d = fire_prev_q;
    prio_d      = prio_q;
    grant_d     = 2'b00;
    drop_d      = 2'b00;
    sel[0]      = first_free;
    sel[1]      = first_free;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      dir_d[i] = dir_q[i];
    end

    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (act_q[i]) begin
          if (off_w[i] || strike_w[i]) begin
            act_d[i] = 1'b0;
          end else begin
            x_d[i] = adv_x[i];
            y_d[i] = adv_y[i];
          end
        end
      end

      case (elig)
        2'b01, 2'b10: begin
          if (have_one) grant_d = elig;
          else          drop_d  = elig;
        end
        2'b11: begin
          if (have_two) begin
            grant_d             = 2'b11;
            sel[prio_q]         = first_free;
            sel[~prio_q]        = second_free;
          end else if (have_one) begin
            grant_d[prio_q]     = 1'b1;
            drop_d[~prio_q]     = 1'b1;
            prio_d              = ~prio_q;
          end else begin
            drop_d              = 2'b11;
          end
        end
        default: ;
      endcase

      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (grant_d[p] && (sel[p] == IW'(i))) begin
            act_d[i]          = 1'b1;
            own_d[i]          = p[0];
            {x_d[i], y_d[i]}  = spawn[p];
            dir_d[i]          = (p == 0) ? bus.tank0_dir : bus.tank1_dir;
          end
        end
        if (grant_d[p])           cd_d[p] = COOLDOWN;
        else if (cd_q[p] != 6'd0) cd_d[p] = cd_q[p] - 6'd1;
      end

      fire_prev_d = bus.fire_req;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_meta_q   <= 1'b0;
      fc_sync_q   <= 1'b0;
      fc_prev_q   <= 1'b0;
      act_q       <= '0;
      own_q       <= '0;
      fire_prev_q <= 2'b00;
      prio_q      <= 1'b0;
      grant_q     <= 2'b00;
      drop_q      <= 2'b00;
      cd_q[0]     <= 6'd0;
      cd_q[1]     <= 6'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]   <= 10'd0;
        y_q[i]   <= 10'd0;
        dir_q[i] <= 3'd0;
      end
    end else begin
      fc_meta_q   <= frame_clk;
      fc_sync_q   <= fc_meta_q;
      fc_prev_q   <= fc_sync_q;
      act_q       <= act_d;
      own_q       <= own_d;
      fire_prev_q <= fire_prev_d;
      prio_q      <= prio_d;
      grant_q     <= grant_d;
      drop_q      <= drop_d;
      cd_q[0]     <= cd_d[0];
      cd_q[1]     <= cd_d[1];
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

`ifdef BULLET_HIT_EN
  logic [1:0] hit_q, hit_d;

  // Any number of strikes on one tank in a tick collapses to a single pulse.
  always_comb begin
    hit_d = 2'b00;
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (strike_w[i]) begin
          if (own_q[i]) hit_d[0] = 1'b1;
          else          hit_d[1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) hit_q <= 2'b00;
    else          hit_q <= hit_d;
  end

  assign bus.hit = hit_q;
`else
  assign bus.hit = 2'b00;
`endif

  always_comb begin
    count_w = 4'd0;
    owner_w = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_w = count_w + {3'b000, act_q[i]};
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cover_w[i]) owner_w = own_q[i];
    end
  end

  assign bus.fire_grant   = grant_q;
  assign bus.fire_drop    = drop_q;
  assign bus.active_count = count_w;
  assign bus.is_bullet    = |cover_w;
  assign bus.bullet_owner = owner_w;

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed bench for bullet_scheduler: spawn, advance, arbitration, cooldown, retire, reset, hit.
module tb_bullet_scheduler;
  logic Clk;
  logic Reset_n;
  logic frame_clk;
  bullet_scheduler_if bus();

  bullet_scheduler dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int g0 = 0, g1 = 0, d0 = 0, d1 = 0, h0 = 0, h1 = 0;
  int tot_g0 = 0, tot_d1 = 0;

  always @(negedge Clk) begin
    if (bus.fire_grant[0]) begin g0++; tot_g0++; end
    if (bus.fire_grant[1]) g1++;
    if (bus.fire_drop[0])  d0++;
    if (bus.fire_drop[1])  begin d1++; tot_d1++; end
    if (bus.hit[0])        h0++;
    if (bus.hit[1])        h1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic clr_counts();
    g0 = 0; g1 = 0; d0 = 0; d1 = 0; h0 = 0; h1 = 0;
  endtask

  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic fire_frame(input string tag, input logic [1:0] req, input logic [1:0] eg, input logic [1:0] ed);
    clr_counts();
    bus.fire_req = req;
    frame();
    $display("frame %s req=%b grants=%0d%0d drops=%0d%0d active=%0d", tag, req, g1, g0, d1, d0, bus.active_count);
    check({tag, " grant0"}, 32'(g0), 32'(eg[0]));
    check({tag, " grant1"}, 32'(g1), 32'(eg[1]));
    check({tag, " drop0"},  32'(d0), 32'(ed[0]));
    check({tag, " drop1"},  32'(d1), 32'(ed[1]));
  endtask

  task automatic idle(input int n, input logic [1:0] req);
    for (int k = 0; k < n; k++) begin
      bus.fire_req = req;
      frame();
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input int e_is, input int e_own);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    #1;
    check({tag, " is_bullet"}, 32'(bus.is_bullet), 32'(e_is));
    check({tag, " owner"},     32'(bus.bullet_owner), 32'(e_own));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n      = 1'b0;
    frame_clk    = 1'b0;
    bus.fire_req = 2'b00;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    Reset_n       = 1'b0;
    frame_clk     = 1'b0;
    bus.fire_req  = 2'b00;
    bus.tank0_X   = 10'd100; bus.tank0_Y = 10'd200; bus.tank0_dir = 3'd2;
    bus.tank1_X   = 10'd400; bus.tank1_Y = 10'd300; bus.tank1_dir = 3'd4;
    bus.DrawX     = 10'd0;   bus.DrawY   = 10'd0;
    repeat (3) @(negedge Clk);
    check("reset active_count", 32'(bus.active_count), 32'd0);
    check("reset grant",        32'(bus.fire_grant), 32'd0);
    check("reset drop",         32'(bus.fire_drop), 32'd0);
    check("reset hit",          32'(bus.hit), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Spawn to the right of player0 and advance one step; player1 fires downward.
    fire_frame("A1", 2'b01, 2'b01, 2'b00);
    check("A1 active", 32'(bus.active_count), 32'd1);
    pix("A1 tl", 132, 212, 1, 0);
    pix("A1 br", 139, 219, 1, 0);
    pix("A1 right out", 140, 219, 0, 0);
    pix("A1 left out", 131, 212, 0, 0);
    fire_frame("A2", 2'b10, 2'b10, 2'b00);
    check("A2 active", 32'(bus.active_count), 32'd2);
    pix("A2 moved", 136, 212, 1, 0);
    pix("A2 vacated", 135, 212, 0, 0);
    pix("A2 p1 spawn", 412, 332, 1, 1);
    pix("A2 p1 corner", 419, 339, 1, 1);
    idle(16, 2'b00);
    fire_frame("A19", 2'b01, 2'b01, 2'b00);
    check("A19 active", 32'(bus.active_count), 32'd3);
    pix("A19 slot2", 132, 212, 1, 0);

    // Asynchronous reset mid-frame with three live bullets.
    @(negedge Clk);
    frame_clk = 1'b1;
    #5;
    Reset_n = 1'b0;
    #1;
    check("midreset active", 32'(bus.active_count), 32'd0);
    check("midreset is_bullet", 32'(bus.is_bullet), 32'd0);
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    fire_frame("R1", 2'b01, 2'b01, 2'b00);
    check("R1 active", 32'(bus.active_count), 32'd1);
    bus.tank1_X = 10'd100; bus.tank1_Y = 10'd200; bus.tank1_dir = 3'd2;
    fire_frame("R2", 2'b10, 2'b10, 2'b00);
    pix("R2 overlap low slot", 137, 213, 1, 0);
    pix("R2 slot1 only", 133, 213, 1, 1);
    pix("R2 slot0 only", 141, 213, 1, 0);

    // Priority arbitration with one free slot, twice.
    do_reset();
    bus.tank0_X = 10'd100; bus.tank0_Y = 10'd200; bus.tank0_dir = 3'd2;
    bus.tank1_X = 10'd400; bus.tank1_Y = 10'd144; bus.tank1_dir = 3'd1;
    fire_frame("B1", 2'b11, 2'b11, 2'b00);
    check("B1 active", 32'(bus.active_count), 32'd2);
    fire_frame("B2", 2'b00, 2'b00, 2'b00);
    idle(14, 2'b00);
    fire_frame("B17", 2'b01, 2'b01, 2'b00);
    fire_frame("B18", 2'b00, 2'b00, 2'b00);
    idle(14, 2'b00);
    fire_frame("B33", 2'b11, 2'b01, 2'b10);
    check("B33 active", 32'(bus.active_count), 32'd4);
    fire_frame("B34", 2'b00, 2'b00, 2'b00);
    fire_frame("B35", 2'b00, 2'b00, 2'b00);
    check("B35 active", 32'(bus.active_count), 32'd4);
    pix("B35 top row", 412, 0, 1, 1);
    fire_frame("B36", 2'b00, 2'b00, 2'b00);
    check("B36 up retire active", 32'(bus.active_count), 32'd3);
    pix("B36 no wrap", 412, 1020, 0, 0);
    pix("B36 top gone", 412, 0, 0, 0);
    idle(12, 2'b00);
    fire_frame("B49", 2'b11, 2'b10, 2'b01);
    check("B49 active", 32'(bus.active_count), 32'd4);

    // Held fire, right-edge retire, invalid dir, cooldown window.
    do_reset();
    bus.tank0_X = 10'd596; bus.tank0_Y = 10'd100; bus.tank0_dir = 3'd2;
    bus.tank1_dir = 3'd0;
    tot_g0 = 0; tot_d1 = 0;
    fire_frame("C1", 2'b11, 2'b01, 2'b00);
    check("C1 active", 32'(bus.active_count), 32'd1);
    pix("C1 edge bullet", 628, 112, 1, 0);
    fire_frame("C2", 2'b11, 2'b00, 2'b00);
    check("C2 right retire active", 32'(bus.active_count), 32'd0);
    idle(38, 2'b11);
    check("C hold grants", 32'(tot_g0), 32'd1);
    check("C bad dir drops", 32'(tot_d1), 32'd0);
    fire_frame("C41", 2'b00, 2'b00, 2'b00);
    fire_frame("C42", 2'b01, 2'b01, 2'b00);
    idle(9, 2'b00);
    fire_frame("C52", 2'b01, 2'b00, 2'b00);
    idle(5, 2'b00);
    fire_frame("C58", 2'b01, 2'b01, 2'b00);

    // Bullet meeting the opposing tank.
    do_reset();
    bus.tank0_X = 10'd258; bus.tank0_Y = 10'd200; bus.tank0_dir = 3'd2;
    bus.tank1_X = 10'd300; bus.tank1_Y = 10'd200; bus.tank1_dir = 3'd4;
    fire_frame("D1", 2'b01, 2'b01, 2'b00);
    fire_frame("D2", 2'b00, 2'b00, 2'b00);
    check("D2 hit0", 32'(h0), 32'd0);
`ifdef BULLET_HIT_EN
    check("D2 hit1", 32'(h1), 32'd1);
    check("D2 active", 32'(bus.active_count), 32'd0);
`else
    check("D2 hit1", 32'(h1), 32'd0);
    check("D2 active", 32'(bus.active_count), 32'd1);
    pix("D2 pass through", 294, 212, 1, 0);
    pix("D2 vacated", 293, 212, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
